mem_arbiter: RTL

Arbitrates the single shared memory port between the IFU (instruction fetch, read-only) and the LSU (loads/stores). It replaces the direct, always-connected IFU/LSU memory paths with valid/ready request handshakes and single-cycle response pulses. At most one transaction is outstanding at a time. A response timeout guarantees forward progress if memory never answers.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Valid/ready requests, one outstanding transaction, and a response timeout.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_resp_data,
  output logic                    ifu_resp_err,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_resp_data,
  output logic                    lsu_resp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RESP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
  } mem_req_t;

  state_t                r_state;
  state_t                w_state_next;
  mem_req_t              r_req;
  logic                  r_owner_lsu;
  logic                  r_prio_ifu;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_ifu_resp_valid;
  logic [DATA_WIDTH-1:0] r_ifu_resp_data;
  logic                  r_ifu_resp_err;
  logic                  r_lsu_resp_valid;
  logic [DATA_WIDTH-1:0] r_lsu_resp_data;
  logic                  r_lsu_resp_err;

  logic                  w_idle;
  logic                  w_grant_ifu;
  logic                  w_grant_lsu;
  logic                  w_resp_ok;
  logic                  w_timeout;
  logic                  w_resp_fire;
  logic [DATA_WIDTH-1:0] w_resp_data;

  // Grant only in IDLE and out of reset; ties go to the favoured requester.
  assign w_idle      = (r_state == S_IDLE) && !rst;
  assign w_grant_ifu = w_idle && ifu_req_valid && (!lsu_req_valid || r_prio_ifu);
  assign w_grant_lsu = w_idle && lsu_req_valid && (!ifu_req_valid || !r_prio_ifu);
  assign w_resp_ok   = (r_state == S_WAIT_RESP) && mem_resp_valid;
  assign w_timeout   = (r_state == S_WAIT_RESP) && !mem_resp_valid &&
                       (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign w_resp_fire = w_resp_ok || w_timeout;
  assign w_resp_data = (w_timeout || r_req.wen) ? '0 : mem_resp_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_grant_ifu || w_grant_lsu) w_state_next = S_ISSUE;
      S_ISSUE:     if (mem_req_ready) w_state_next = S_WAIT_RESP;
      S_WAIT_RESP: if (w_resp_fire) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Request latch, owner tracking and tie-break flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= '0;
      r_owner_lsu <= 1'b0;
      r_prio_ifu  <= 1'b1;
    end else if (w_grant_ifu) begin
      r_req.addr  <= ifu_req_addr;
      r_req.wen   <= 1'b0;
      r_req.wdata <= '0;
      r_req.wmask <= '0;
      r_owner_lsu <= 1'b0;
      if (lsu_req_valid) r_prio_ifu <= 1'b0;
    end else if (w_grant_lsu) begin
      r_req.addr  <= lsu_req_addr;
      r_req.wen   <= lsu_req_wen;
      r_req.wdata <= lsu_req_wdata;
      r_req.wmask <= lsu_req_wmask;
      r_owner_lsu <= 1'b1;
      if (ifu_req_valid) r_prio_ifu <= 1'b1;
    end
  end

  // Counts cycles spent waiting; cleared whenever not waiting.
  always_ff @(posedge clk) begin
    if (rst)                          r_cnt <= '0;
    else if (r_state == S_WAIT_RESP)  r_cnt <= r_cnt + CNT_WIDTH'(1);
    else                              r_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifu_resp_valid <= 1'b0;
      r_ifu_resp_data  <= '0;
      r_ifu_resp_err   <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      r_lsu_resp_data  <= '0;
      r_lsu_resp_err   <= 1'b0;
    end else begin
      r_ifu_resp_valid <= w_resp_fire && !r_owner_lsu;
      r_lsu_resp_valid <= w_resp_fire && r_owner_lsu;
      if (w_resp_fire && !r_owner_lsu) begin
        r_ifu_resp_data <= w_resp_data;
        r_ifu_resp_err  <= w_timeout;
      end
      if (w_resp_fire && r_owner_lsu) begin
        r_lsu_resp_data <= w_resp_data;
        r_lsu_resp_err  <= w_timeout;
      end
    end
  end

  assign ifu_req_ready  = w_grant_ifu;
  assign lsu_req_ready  = w_grant_lsu;
  assign ifu_resp_valid = r_ifu_resp_valid;
  assign ifu_resp_data  = r_ifu_resp_data;
  assign ifu_resp_err   = r_ifu_resp_err;
  assign lsu_resp_valid = r_lsu_resp_valid;
  assign lsu_resp_data  = r_lsu_resp_data;
  assign lsu_resp_err   = r_lsu_resp_err;
  assign mem_req_valid  = (r_state == S_ISSUE);
  assign mem_req_addr   = r_req.addr;
  assign mem_req_wen    = r_req.wen;
  assign mem_req_wdata  = r_req.wdata;
  assign mem_req_wmask  = r_req.wmask;

endmodule
